// File: rtl/xc_msk_arith_unit.sv
// Arithmetic-masking execute unit: mask, unmask, remask, add, sub.
// Shares satisfy x = s0 - s1; one shared adder builds s1 then s0.
module xc_msk_arith_unit #(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] rs1_s0,
  input  logic [XLEN-1:0] rs1_s1,
  input  logic [XLEN-1:0] rs2_s0,
  input  logic [XLEN-1:0] rs2_s1,
  input  logic [XLEN-1:0] prng,
  output logic            prng_update,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_s0,
  output logic [XLEN-1:0] rsp_s1,
  output logic            rsp_wide,
  output logic            rsp_trap
);

  typedef enum logic [1:0] {
    IDLE,
    SH1,
    SH0,
    DONE
  } state_t;

  localparam logic [2:0] OP_MASK   = 3'd0;
  localparam logic [2:0] OP_UNMASK = 3'd1;
  localparam logic [2:0] OP_REMASK = 3'd2;
  localparam logic [2:0] OP_ADD    = 3'd3;
  localparam logic [2:0] OP_SUB    = 3'd4;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a0_q, a0_d;
  logic [XLEN-1:0] a1_q, a1_d;
  logic [XLEN-1:0] b0_q, b0_d;
  logic [XLEN-1:0] b1_q, b1_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] s0_q, s0_d;
  logic [XLEN-1:0] s1_q, s1_d;
  logic            wide_q, wide_d;
  logic            trap_q, trap_d;

  logic            accept;
  logic            op_legal;
  logic [XLEN-1:0] add_x;
  logic [XLEN-1:0] add_y;
  logic            add_sub;
  logic [XLEN-1:0] add_res;

  assign accept   = (state_q == IDLE) & req_valid
                  & ~flush & ~g_reset;
  assign op_legal = (req_op <= OP_SUB);

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_s0      = s0_q;
  assign rsp_s1      = s1_q;
  assign rsp_wide    = wide_q;
  assign rsp_trap    = trap_q;
  assign prng_update = accept
                     & ((req_op == OP_MASK) | (req_op == OP_REMASK));

  // Single adder; operand selection keeps s0 and s1 in separate passes.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (state_q == SH1) begin
      unique case (1'b1)
        (op_q == OP_MASK): begin
          add_y = r_q;
        end
        (op_q == OP_REMASK): begin
          add_x = a1_q;
          add_y = r_q;
        end
        (op_q == OP_ADD): begin
          add_x = a1_q;
          add_y = b1_q;
        end
        (op_q == OP_SUB): begin
          add_x   = a1_q;
          add_y   = b1_q;
          add_sub = 1'b1;
        end
        default: ;
      endcase
    end else if (state_q == SH0) begin
      unique case (1'b1)
        (op_q == OP_MASK),
        (op_q == OP_REMASK): begin
          add_x = a0_q;
          add_y = r_q;
        end
        (op_q == OP_UNMASK): begin
          add_x   = a0_q;
          add_y   = a1_q;
          add_sub = 1'b1;
        end
        (op_q == OP_ADD): begin
          add_x = a0_q;
          add_y = b0_q;
        end
        (op_q == OP_SUB): begin
          add_x   = a0_q;
          add_y   = b0_q;
          add_sub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign add_res = add_x
                 + (add_sub ? ~add_y : add_y)
                 + XLEN'(add_sub);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    r_d     = r_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    wide_d  = wide_q;
    trap_d  = trap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = req_op;
          a0_d = rs1_s0;
          a1_d = rs1_s1;
          b0_d = rs2_s0;
          b1_d = rs2_s1;
          r_d  = prng;
          s0_d = '0;
          s1_d = '0;
          wide_d = 1'b0;
          if (!op_legal) begin
            trap_d  = 1'b1;
            state_d = DONE;
          end else if (req_op == OP_UNMASK) begin
            state_d = SH0;
          end else begin
            state_d = SH1;
          end
        end
      end
      SH1: begin
        s1_d    = add_res;
        state_d = SH0;
      end
      SH0: begin
        s0_d    = add_res;
        wide_d  = (op_q != OP_UNMASK);
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          s0_d    = '0;
          s1_d    = '0;
          wide_d  = 1'b0;
          trap_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wipes the result bus so no share survives a flush.
    if (flush) begin
      s0_d    = '0;
      s1_d    = '0;
      wide_d  = 1'b0;
      trap_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      r_q     <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      wide_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      r_q     <= r_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      wide_q  <= wide_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_xc_msk_arith_unit.sv
// Directed bench for xc_msk_arith_unit.
// Hand-computed vectors for every op, flush, reset and backpressure.
module tb_xc_msk_arith_unit;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] rs1_s0, rs1_s1, rs2_s0, rs2_s1;
  logic [31:0] prng;
  logic        prng_update;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_s0, rsp_s1;
  logic        rsp_wide;
  logic        rsp_trap;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  xc_msk_arith_unit #(.XLEN(32)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .rs1_s0     (rs1_s0),
    .rs1_s1     (rs1_s1),
    .rs2_s0     (rs2_s0),
    .rs2_s1     (rs2_s1),
    .prng       (prng),
    .prng_update(prng_update),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_s0     (rsp_s0),
    .rsp_s1     (rsp_s1),
    .rsp_wide   (rsp_wide),
    .rsp_trap   (rsp_trap)
  );

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Present a request for one cycle; pu is prng_update in that cycle.
  task automatic send(input logic [2:0] op,
                      input logic [31:0] a0, a1, b0, b1, r,
                      output logic pu);
    req_valid = 1'b1;
    req_op    = op;
    rs1_s0    = a0;
    rs1_s1    = a1;
    rs2_s0    = b0;
    rs2_s1    = b1;
    prng      = r;
    #1;
    pu = prng_update;
    step();
    req_valid = 1'b0;
    prng      = 32'hDEADBEEF;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    step();
    step();
    g_reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_wide, rsp_trap, prng_update} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b exp 0000",
               rsp_valid, rsp_wide, rsp_trap, prng_update);
    end
    checks++;
    if ({rsp_s0, rsp_s1} !== 64'h0) begin
      errors++;
      $display("FAIL reset_shares got %h %h exp 0 0", rsp_s0, rsp_s1);
    end
  endtask

  task automatic test_mask();
    logic pu;
    int lat;
    send(3'd0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, pu);
    checks++;
    if (pu !== 1'b1) begin
      errors++;
      $display("FAIL mask_prng_update got %b exp 1", pu);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL mask_latency got %0d exp 3", lat);
    end
    checks++;
    if (rsp_s0 !== 32'h21436587 || rsp_s1 !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL mask_shares got %h %h exp 21436587 0f0f0f0f",
               rsp_s0, rsp_s1);
    end
    checks++;
    if (rsp_wide !== 1'b1 || rsp_trap !== 1'b0) begin
      errors++;
      $display("FAIL mask_wide_trap got %b %b exp 1 0", rsp_wide, rsp_trap);
    end
    ack();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_s0 !== 32'h0 || rsp_s1 !== 32'h0
        || rsp_wide !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mask_clear got v%b %h %h w%b r%b exp v0 0 0 w0 r1",
               rsp_valid, rsp_s0, rsp_s1, rsp_wide, req_ready);
    end
  endtask

  task automatic test_unmask();
    logic pu;
    int lat;
    send(3'd1, 32'h5, 32'h7, 32'h0, 32'h0, 32'hAAAA5555, pu);
    checks++;
    if (pu !== 1'b0) begin
      errors++;
      $display("FAIL unmask_prng_update got %b exp 0", pu);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL unmask_latency got %0d exp 2", lat);
    end
    checks++;
    if (rsp_s0 !== 32'hFFFFFFFE || rsp_s1 !== 32'h0
        || rsp_wide !== 1'b0) begin
      errors++;
      $display("FAIL unmask_result got %h %h w%b exp fffffffe 0 w0",
               rsp_s0, rsp_s1, rsp_wide);
    end
    ack();
  endtask

  task automatic test_remask();
    logic pu;
    int lat;
    send(3'd2, 32'h10, 32'h20, 32'h0, 32'h0, 32'hFFFFFFFF, pu);
    checks++;
    if (pu !== 1'b1) begin
      errors++;
      $display("FAIL remask_prng_update got %b exp 1", pu);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_s0 !== 32'h0F || rsp_s1 !== 32'h1F) begin
      errors++;
      $display("FAIL remask_result got lat%0d %h %h exp lat3 f 1f",
               lat, rsp_s0, rsp_s1);
    end
    checks++;
    if (rsp_s0 - rsp_s1 !== 32'hFFFFFFF0) begin
      errors++;
      $display("FAIL remask_value got %h exp fffffff0", rsp_s0 - rsp_s1);
    end
    ack();
  endtask

  task automatic test_sub_backpressure();
    logic pu;
    int lat;
    int bad;
    send(3'd4, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, pu);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_s0 !== 32'hFFFFFFFF || rsp_s1 !== 32'h1) begin
      errors++;
      $display("FAIL sub_result got lat%0d %h %h exp lat3 ffffffff 1",
               lat, rsp_s0, rsp_s1);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_s0 !== 32'hFFFFFFFF
          || rsp_s1 !== 32'h1 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sub_hold got %0d unstable cycles exp 0", bad);
    end
    ack();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_release got r%b v%b exp r1 v0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic pu;
    int lat;
    send(3'd3, 32'h5, 32'h3, 32'h7, 32'h2, 32'h0, pu);
    wait_rsp(lat);
    checks++;
    if (rsp_s0 !== 32'hC || rsp_s1 !== 32'h5 || rsp_wide !== 1'b1) begin
      errors++;
      $display("FAIL add_result got %h %h w%b exp c 5 w1",
               rsp_s0, rsp_s1, rsp_wide);
    end
    req_valid = 1'b1;
    req_op    = 3'd3;
    rs1_s0    = 32'hFFFFFFFF;
    rs1_s1    = 32'h80000000;
    rs2_s0    = 32'h2;
    rs2_s1    = 32'h80000001;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_not_early got r%b v%b exp r1 v0",
               req_ready, rsp_valid);
    end
    step();
    req_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_s0 !== 32'h1 || rsp_s1 !== 32'h1) begin
      errors++;
      $display("FAIL b2b_result got lat%0d %h %h exp lat3 1 1",
               lat, rsp_s0, rsp_s1);
    end
    ack();
  endtask

  task automatic test_flush();
    logic pu;
    int lat;
    send(3'd3, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0, pu);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    #1;
    checks++;
    if (prng_update !== 1'b0) begin
      errors++;
      $display("FAIL flush_prng_update got %b exp 0", prng_update);
    end
    step();
    flush = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_s0 !== 32'h0
        || rsp_s1 !== 32'h0 || rsp_wide !== 1'b0) begin
      errors++;
      $display("FAIL flush_state got v%b r%b %h %h w%b exp v0 r1 0 0 w0",
               rsp_valid, req_ready, rsp_s0, rsp_s1, rsp_wide);
    end
    req_valid = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_no_accept got r%b exp 1", req_ready);
    end
    send(3'd3, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0, pu);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_s0 !== 32'h44 || rsp_s1 !== 32'h66) begin
      errors++;
      $display("FAIL flush_after got lat%0d %h %h exp lat3 44 66",
               lat, rsp_s0, rsp_s1);
    end
    ack();
  endtask

  task automatic test_illegal_and_reset();
    logic pu;
    int lat;
    send(3'd6, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, pu);
    wait_rsp(lat);
    checks++;
    if (lat != 1 || rsp_trap !== 1'b1 || pu !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap got lat%0d t%b pu%b exp lat1 t1 pu0",
               lat, rsp_trap, pu);
    end
    checks++;
    if (rsp_s0 !== 32'h0 || rsp_s1 !== 32'h0 || rsp_wide !== 1'b0) begin
      errors++;
      $display("FAIL illegal_shares got %h %h w%b exp 0 0 w0",
               rsp_s0, rsp_s1, rsp_wide);
    end
    ack();
    checks++;
    if (rsp_trap !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got t%b exp 0", rsp_trap);
    end
    send(3'd0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, pu);
    step();
    checks++;
    if (rsp_s1 !== 32'h0F0F0F0F || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midmask_s1 got %h r%b exp 0f0f0f0f r0",
               rsp_s1, req_ready);
    end
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_s0 !== 32'h0
        || rsp_s1 !== 32'h0 || rsp_wide !== 1'b0 || rsp_trap !== 1'b0) begin
      errors++;
      $display("FAIL midmask_reset got r%b v%b %h %h w%b t%b exp r1 v0 0 0",
               req_ready, rsp_valid, rsp_s0, rsp_s1, rsp_wide, rsp_trap);
    end
  endtask

  initial begin
    g_reset   = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    rs1_s0    = '0;
    rs1_s1    = '0;
    rs2_s0    = '0;
    rs2_s1    = '0;
    prng      = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_mask();
    test_unmask();
    test_remask();
    test_sub_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xc_msk_arith_unit.md
Name: xc_msk_arith_unit

Overview:
- Execute-stage functional unit for the arithmetic-masking instructions: mask.a.mask, mask.a.unmask, mask.a.remask, mask.a.add and mask.a.sub.
- Sits directly upstream of writeback and the RVFI trace. It produces the rd / rd-hi values that the per-instruction formal models check.
- Shares use the arithmetic relation x = s0 - s1 (mod 2^32).
- One shared adder computes share 1 and share 0 in separate cycles, so the two shares of a value are never combined in one adder pass, except in unmask by definition.

Parameters:
XLEN, 32, datapath and share width.

Ports:
g_clk  in  1  clock.
g_reset  in  1  synchronous active-high reset.
flush  in  1  abort any in-flight operation.
req_valid  in  1  request valid.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_op  in  3  0=MASK 1=UNMASK 2=REMASK 3=ADD 4=SUB; 5..7 illegal.
rs1_s0  in  XLEN  operand A share 0 (plain value for MASK).
rs1_s1  in  XLEN  operand A share 1.
rs2_s0  in  XLEN  operand B share 0.
rs2_s1  in  XLEN  operand B share 1.
prng  in  XLEN  fresh randomness.
prng_update  out  1  one-cycle pulse: prng value consumed.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_s0  out  XLEN  result share 0 (rd value).
rsp_s1  out  XLEN  result share 1 (rd-hi value).
rsp_wide  out  1  result is a share pair (rd wide write).
rsp_trap  out  1  illegal op.

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Internal operand and prng registers cleared.
- FSM states: IDLE, SH1, SH0, DONE.
- IDLE: req_ready=1. On req_valid, with no flush and no reset (accept edge T):
  - Latch op, the four operands and prng.
  - Drive prng_update=1 in cycle T, only for MASK and REMASK.
  - Next state: SH1 for MASK, REMASK, ADD, SUB; SH0 for UNMASK; DONE for an illegal op, with rsp_trap=1 and both shares 0.
- SH1: register rsp_s1, then go to SH0.
  - MASK: r
  - REMASK: a1+r
  - ADD: a1+b1
  - SUB: a1-b1
- SH0: register rsp_s0, then go to DONE.
  - MASK: a0+r, where a0 is the plain value
  - UNMASK: a0-a1
  - REMASK: a0+r
  - ADD: a0+b0
  - SUB: a0-b0
- Arithmetic: all operations are mod 2^32, with no carry-out or flags.
- UNMASK result: rsp_s1=0, rsp_wide=0. All other legal ops: rsp_wide=1.
- DONE: rsp_valid=1; rsp_* held stable. On rsp_ready, go to IDLE, clear rsp_valid and zero rsp_s0, rsp_s1, rsp_wide and rsp_trap, so shares do not linger on the bus.
- Latency, accept edge to first rsp_valid cycle: 3 cycles for 2-share ops, 2 for UNMASK, 1 for illegal.
- Throughput: at most one operation in flight. req_ready=0 in SH1, SH0 and DONE, so a back-to-back request is accepted at the earliest in the cycle after the DONE handshake.
- Backpressure: rsp_ready low holds DONE indefinitely with stable outputs.
- flush: priority over all other events, in any state:
  - Next state IDLE; rsp_valid and all rsp_* are zeroed next cycle.
  - A req_valid in the same cycle is not accepted, and prng_update stays 0.
- g_reset: same effect as flush, and additionally clears the operand registers. Reset has priority over flush.
- prng is sampled only at the accept edge. A prng change after accept does not affect the result.

Test Plan:
1. MASK a0=0x12345678, prng=0x0F0F0F0F -> prng_update pulse at accept; rsp_valid at T+3 with rsp_s0=0x21436587, rsp_s1=0x0F0F0F0F, rsp_wide=1.
2. UNMASK s0=0x00000005, s1=0x00000007 -> rsp_valid at T+2 with rsp_s0=0xFFFFFFFE, rsp_s1=0, rsp_wide=0, no prng_update.
3. REMASK s0=0x10, s1=0x20, prng=0xFFFFFFFF -> rsp_s0=0x0F, rsp_s1=0x1F; s0-s1 is still 0xFFFFFFF0.
4. SUB a=(0x0,0x1), b=(0x1,0x0), then hold rsp_ready=0 for 5 cycles -> rsp_s0=0xFFFFFFFF, rsp_s1=0x1, stable throughout; req_ready=0 until the handshake, then 1.
5. Flush in SH1 of an ADD, with req_valid asserted in the same cycle -> next cycle IDLE, rsp_valid=0, rsp_* all 0, no accept; a request the following cycle completes normally.
6. req_op=6 -> rsp_valid at T+1, rsp_trap=1, rsp_s0=rsp_s1=0; also assert g_reset mid-MASK -> all outputs 0 and req_ready=1 next cycle.
